// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack slave with WAIT_CYCLES wait states over an internal word array.
// Optional DMEM_RESPONDER_ERR_EN flags illegal byte-lane masks instead of applying them literally.
module dmem_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int WAIT_CYCLES    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] transfer_i,
  output logic                      busy_o,
  output logic                      ack_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                      state;
  logic [3:0]                  cnt;
  logic                        we_q;
  logic [ADDR_WIDTH-3:0]       idx_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [TRANSFER_WIDTH-1:0]   mask_q;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];

  logic                        wr_we;
  logic [ADDR_WIDTH-3:0]       wr_idx;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic [TRANSFER_WIDTH-1:0]   wr_mask;
  logic                        wr_ok;
  logic                        mask_ok;
  logic                        enter_resp;
  logic [DATA_WIDTH-1:0]       lane_bits;
  logic                        unused_addr;

  assign unused_addr = ^addr_i[1:0];

`ifdef DMEM_RESPONDER_ERR_EN
  function automatic logic legal_mask(input logic [TRANSFER_WIDTH-1:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: legal_mask = 1'b1;
      default: legal_mask = 1'b0;
    endcase
  endfunction
  assign wr_ok   = legal_mask(wr_mask);
  assign mask_ok = legal_mask(mask_q);
`else
  assign wr_ok   = 1'b1;
  assign mask_ok = 1'b1;
`endif

  // With zero wait states RESP is entered straight from IDLE, so the write uses the live request.
  always_comb begin
    if (state == IDLE) begin
      wr_we   = we_i;
      wr_idx  = addr_i[ADDR_WIDTH-1:2];
      wr_data = wdata_i;
      wr_mask = transfer_i;
    end else begin
      wr_we   = we_q;
      wr_idx  = idx_q;
      wr_data = wdata_q;
      wr_mask = mask_q;
    end
  end

  assign enter_resp = !rst &&
                      (((state == IDLE) && req_i && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 4'd0)));

  always_comb begin
    lane_bits = '0;
    for (int b = 0; b < TRANSFER_WIDTH; b++) begin
      lane_bits[8*b +: 8] = {8{mask_q[b]}};
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (enter_resp && wr_we && wr_ok) begin
      for (int b = 0; b < TRANSFER_WIDTH; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      ack_o   <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[ADDR_WIDTH-1:2];
            wdata_q <= wdata_i;
            mask_q  <= transfer_i;
            busy_o  <= 1'b1;
            cnt     <= WAIT_INIT;
            state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          ack_o  <= 1'b1;
`ifdef DMEM_RESPONDER_ERR_EN
          err_o  <= !mask_ok;
`endif
          if (!we_q && mask_ok) rdata_o <= mem[idx_q] & lane_bits;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, we = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic        busy, ack, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [9:0]  addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic [3:0]  mask0 = '0;
  logic        busy0, ack0, err0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        e;
  int          lat;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TRANSFER_WIDTH(4), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .transfer_i(mask), .busy_o(busy), .ack_o(ack), .rdata_o(rdata), .err_o(err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TRANSFER_WIDTH(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wdata0),
    .transfer_i(mask0), .busy_o(busy0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one request on the one-wait-state instance; lat counts rising edges from accept to ack.
  task automatic xact(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m,
                      output logic [31:0] r, output logic er, output int l);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; mask = m;
    @(posedge clk);
    l = 0;
    r = '0;
    er = 1'b0;
    forever begin
      @(negedge clk);
      if (ack) begin
        r = rdata; er = err;
        break;
      end
      if (l == 0) chk("busy_during_wait", {31'd0, busy}, 32'd1);
      if (l > 20) begin
        chk("ack_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      l++;
    end
    req = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", {busy, ack, rdata[29:0]} | {2'b00, rdata[31:30], 28'd0}, 32'd0);
    end

    xact(1'b1, 10'h010, 32'hDEADBEEF, 4'b1111, rd, e, lat);
    chk("store_word_lat", lat, 32'd2);
    chk("store_word_err", {31'd0, e}, 32'd0);
    xact(1'b0, 10'h010, 32'h0, 4'b1111, rd, e, lat);
    chk("load_word_lat", lat, 32'd2);
    chk("load_word_data", rd, 32'hDEADBEEF);
    chk("load_word_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("rdata_after_ack", rdata, 32'd0);
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);

    xact(1'b1, 10'h010, 32'h00AA0000, 4'b0100, rd, e, lat);
    xact(1'b0, 10'h010, 32'h0, 4'b1111, rd, e, lat);
    chk("byte_store_merge", rd, 32'hDEAABEEF);
    xact(1'b0, 10'h012, 32'h0, 4'b1100, rd, e, lat);
    chk("half_load_mask", rd, 32'hDEAA0000);

    // Abort a store with reset while it sits in WAIT.
    xact(1'b1, 10'h020, 32'h12345678, 4'b1111, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'h55555555; mask = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_ack", {30'd0, ack, busy}, 32'd0);
      @(negedge clk);
    end
    xact(1'b0, 10'h020, 32'h0, 4'b1111, rd, e, lat);
    chk("abort_prior_data", rd, 32'h12345678);

    // Reset while in RESP: ack suppressed, write stays.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'h030; wdata = 32'hAABBCCDD; mask = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("resp_reset_no_ack", {31'd0, ack}, 32'd0);
    xact(1'b0, 10'h030, 32'h0, 4'b1111, rd, e, lat);
    chk("resp_reset_committed", rd, 32'hAABBCCDD);

    xact(1'b1, 10'h010, 32'h11223344, 4'b0101, rd, e, lat);
`ifdef DMEM_RESPONDER_ERR_EN
    chk("mask0101_err", {31'd0, e}, 32'd1);
    xact(1'b0, 10'h010, 32'h0, 4'b1111, rd, e, lat);
    chk("mask0101_unchanged", rd, 32'hDEAABEEF);
`else
    chk("mask0101_err", {31'd0, e}, 32'd0);
    xact(1'b0, 10'h010, 32'h0, 4'b1111, rd, e, lat);
    chk("mask0101_literal", rd, 32'hDE22BE44);
`endif

    // Zero-wait instance with request held across four stores.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h004; wdata0 = 32'hCAFEF00D; mask0 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) chk("w0_busy_phase", {30'd0, busy0, ack0}, 32'd2);
      else            chk("w0_ack_phase",  {30'd0, busy0, ack0}, 32'd1);
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("w0_idle_after", {30'd0, busy0, ack0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; mask0 = 4'b0011;
    @(negedge clk);
    chk("w0_load_busy", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    chk("w0_load_ack", {31'd0, ack0}, 32'd1);
    chk("w0_load_data", rdata0, 32'h0000F00D);
    req0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
